// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and stall controller for the 5-stage CPU54 pipeline.
// It keeps a shadow scoreboard of in-flight register-file writes (EX/MEM/WB)
// and a mult/div busy counter, and decides each cycle whether the
// instruction sitting in ID may issue.
//
// Ports:
//   clk, rst_n            pipeline clock (rising edge), async active-low reset
//   id_valid              ID holds a real instruction
//   id_rs, id_rt          source register fields of the ID instruction
//   id_rs_used/_rt_used   the ID instruction actually reads rs / rt
//   id_rf_wena            the ID instruction writes the regfile
//   id_rf_waddr           final write address of the ID instruction
//   id_redirect           branch taken / jump resolved in ID
//   id_is_muldiv          ID instruction is mult/multu/div/divu
//   id_md_cycles          execution latency of that mult/div
//   id_uses_hilo          ID instruction touches HI/LO (incl. mult/div)
//   if_pc_sel             IF PC mux: 00 PC+4, 01 ID-resolved PC, 10 hold
//   id_hold               freeze IF/ID register and PC
//   ex_bubble             load a NOP into ID/EX this cycle
//   md_busy               mult/div counter nonzero
//   stall_cnt             stalled cycles since reset (wraps)
module pipe_hazard_ctrl #(
  parameter int MD_CNT_W  = 6,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic                id_rf_wena,
  input  logic [4:0]          id_rf_waddr,
  input  logic                id_redirect,
  input  logic                id_is_muldiv,
  input  logic [MD_CNT_W-1:0] id_md_cycles,
  input  logic                id_uses_hilo,
  output logic [1:0]          if_pc_sel,
  output logic                id_hold,
  output logic                ex_bubble,
  output logic                md_busy,
  output logic [31:0]         stall_cnt
);

  localparam logic [MD_CNT_W-1:0] MD_ZERO = {MD_CNT_W{1'b0}};
  localparam logic [MD_CNT_W-1:0] MD_ONE  = {{(MD_CNT_W-1){1'b0}}, 1'b1};

  // Scoreboard of pending regfile writes, one slot per downstream stage.
  logic                ex_v_r, mem_v_r, wb_v_r;
  logic [4:0]          ex_a_r, mem_a_r, wb_a_r;
  logic [MD_CNT_W-1:0] md_cnt_r;
  logic [31:0]         stall_cnt_r;

  logic                raw_s;
  logic                md_haz_s;
  logic                stall_s;
  logic                issue_s;
  logic                md_busy_s;

  // True when register r has a write in flight that ID cannot yet see.
  // $0 is never tracked, and WB only counts when the regfile lacks
  // write-before-read.
  function automatic logic reg_match_f(
    input logic [4:0] r,
    input logic       ex_v,
    input logic [4:0] ex_a,
    input logic       mem_v,
    input logic [4:0] mem_a,
    input logic       wb_v,
    input logic [4:0] wb_a
  );
    logic hit;
    hit = (ex_v && (ex_a == r)) || (mem_v && (mem_a == r)) ||
          (!WB_BYPASS && wb_v && (wb_a == r));
    return (r != 5'd0) && hit;
  endfunction

  // Hazard detection and issue decision for the ID instruction.
  always_comb begin
    raw_s     = 1'b0;
    md_haz_s  = 1'b0;
    stall_s   = 1'b0;
    issue_s   = 1'b0;
    md_busy_s = (md_cnt_r != MD_ZERO);
    // The *_used qualifiers come first so an unused operand field never
    // contributes, whatever value it carries.
    raw_s = (id_rs_used && reg_match_f(id_rs, ex_v_r, ex_a_r, mem_v_r, mem_a_r, wb_v_r, wb_a_r)) ||
            (id_rt_used && reg_match_f(id_rt, ex_v_r, ex_a_r, mem_v_r, mem_a_r, wb_v_r, wb_a_r));
    md_haz_s = id_uses_hilo && md_busy_s;
    if (id_valid) begin
      stall_s = raw_s || md_haz_s;
    end else begin
      stall_s = 1'b0;
    end
    issue_s = id_valid && !stall_s;
  end

  // PC mux select: a stall wins over a redirect because the branch
  // operands it was resolved from are not valid yet.
  always_comb begin
    if_pc_sel = 2'b00;
    if (stall_s) begin
      if_pc_sel = 2'b10;
    end else if (id_valid && id_redirect) begin
      if_pc_sel = 2'b01;
    end else begin
      if_pc_sel = 2'b00;
    end
  end

  assign id_hold   = stall_s;
  assign ex_bubble = stall_s || !id_valid;
  assign md_busy   = md_busy_s;
  assign stall_cnt = stall_cnt_r;

  // Scoreboard shift, mult/div occupancy counter and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_r      <= 1'b0;
      ex_a_r      <= 5'd0;
      mem_v_r     <= 1'b0;
      mem_a_r     <= 5'd0;
      wb_v_r      <= 1'b0;
      wb_a_r      <= 5'd0;
      md_cnt_r    <= MD_ZERO;
      stall_cnt_r <= 32'd0;
    end else begin
      wb_v_r  <= mem_v_r;
      wb_a_r  <= mem_a_r;
      mem_v_r <= ex_v_r;
      mem_a_r <= ex_a_r;
      // A stalled or bubbled slot enters EX as an empty entry.
      ex_v_r  <= issue_s && id_rf_wena && (id_rf_waddr != 5'd0);
      ex_a_r  <= id_rf_waddr;

      if (issue_s && id_is_muldiv) begin
        md_cnt_r <= id_md_cycles;
      end else if (md_cnt_r != MD_ZERO) begin
        md_cnt_r <= md_cnt_r - MD_ONE;
      end else begin
        md_cnt_r <= md_cnt_r;
      end

      if (stall_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Two instances share all inputs:
// index 0 is built with WB_BYPASS = 1, index 1 with WB_BYPASS = 0.
// A history-based model predicts every output on each falling edge.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = 5'd0;
  logic [4:0] id_rt = 5'd0;
  logic       id_rs_used = 1'b0;
  logic       id_rt_used = 1'b0;
  logic       id_rf_wena = 1'b0;
  logic [4:0] id_rf_waddr = 5'd0;
  logic       id_redirect = 1'b0;
  logic       id_is_muldiv = 1'b0;
  logic [5:0] id_md_cycles = 6'd0;
  logic       id_uses_hilo = 1'b0;

  logic [1:0]  sel_a, sel_b;
  logic        hold_a, hold_b, bub_a, bub_b, busy_a, busy_b;
  logic [31:0] cnt_a, cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_CNT_W(6), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rf_wena(id_rf_wena),
    .id_rf_waddr(id_rf_waddr), .id_redirect(id_redirect), .id_is_muldiv(id_is_muldiv),
    .id_md_cycles(id_md_cycles), .id_uses_hilo(id_uses_hilo),
    .if_pc_sel(sel_a), .id_hold(hold_a), .ex_bubble(bub_a), .md_busy(busy_a), .stall_cnt(cnt_a)
  );

  pipe_hazard_ctrl #(.MD_CNT_W(6), .WB_BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rf_wena(id_rf_wena),
    .id_rf_waddr(id_rf_waddr), .id_redirect(id_redirect), .id_is_muldiv(id_is_muldiv),
    .id_md_cycles(id_md_cycles), .id_uses_hilo(id_uses_hilo),
    .if_pc_sel(sel_b), .id_hold(hold_b), .ex_bubble(bub_b), .md_busy(busy_b), .stall_cnt(cnt_b)
  );

  // ---------------- reference model ----------------
  // hist[m][k] = destination register of the instruction issued k+1 cycles
  // ago (0 = nothing written). md_until[m] = last cycle the mult/div unit
  // is still occupied. mcyc counts rising edges since reset.
  logic [4:0]  hist[2][3];
  int          md_until[2];
  logic [31:0] mtot[2];
  int          mcyc = 0;
  bit          p_stall[2];
  bit          p_md[2];
  logic [4:0]  p_dest[2];
  logic [5:0]  p_mdn = 6'd0;

  function automatic bit hit(int m, logic [4:0] r);
    int depth = (m == 0) ? 2 : 3;
    if (r == 5'd0) return 1'b0;
    for (int k = 0; k < depth; k++) begin
      if (hist[m][k] == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) hist[m][k] = 5'd0;
      md_until[m] = -1;
      mtot[m] = 32'd0;
      p_stall[m] = 1'b0;
      p_md[m] = 1'b0;
      p_dest[m] = 5'd0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int m = 0; m < 2; m++) begin
          for (int k = 0; k < 3; k++) hist[m][k] = 5'd0;
          md_until[m] = -1;
          mtot[m] = 32'd0;
        end
        mcyc = 0;
      end else begin
        for (int m = 0; m < 2; m++) begin
          hist[m][2] = hist[m][1];
          hist[m][1] = hist[m][0];
          hist[m][0] = p_dest[m];
          if (p_md[m]) md_until[m] = mcyc + int'(p_mdn);
          if (p_stall[m]) mtot[m] = mtot[m] + 32'd1;
        end
        mcyc = mcyc + 1;
      end
    end
  end

  // Compare process: every falling edge, both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        bit raw, busy, st;
        logic [1:0]  es;
        logic [36:0] expv, gotv;
        raw  = (id_rs_used && hit(m, id_rs)) || (id_rt_used && hit(m, id_rt));
        busy = (mcyc <= md_until[m]);
        st   = id_valid && (raw || (id_uses_hilo && busy));
        es   = st ? 2'b10 : ((id_valid && id_redirect) ? 2'b01 : 2'b00);
        expv = {es, st, st || !id_valid, busy, mtot[m]};
        gotv = (m == 0) ? {sel_a, hold_a, bub_a, busy_a, cnt_a}
                        : {sel_b, hold_b, bub_b, busy_b, cnt_b};
        checks++;
        if (gotv !== expv) begin
          failures++;
          $display("FAIL model_cmp inst=%0d t=%0t got{sel,hold,bub,busy,cnt}=%h want=%h",
                   m, $time, gotv, expv);
        end
        p_stall[m] = st;
        p_md[m]    = id_valid && !st && id_is_muldiv;
        p_dest[m]  = (id_valid && !st && id_rf_wena) ? id_rf_waddr : 5'd0;
      end
      p_mdn = id_md_cycles;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic drv(bit v, logic [4:0] rs, bit rsu, logic [4:0] rt, bit rtu,
                     bit we, logic [4:0] wa, bit redir, bit md, logic [5:0] mdc, bit hilo);
    @(posedge clk);
    #1;
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rf_wena = we; id_rf_waddr = wa; id_redirect = redir;
    id_is_muldiv = md; id_md_cycles = mdc; id_uses_hilo = hilo;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // Reset held across two falling edges so the model sees it cleanly.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs_used = 1'b0; id_rt_used = 1'b0; id_rf_wena = 1'b0;
    id_redirect = 1'b0; id_is_muldiv = 1'b0; id_uses_hilo = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    at_neg();
    chk("rst_sel", {30'd0, sel_a}, 32'd0);
    chk("rst_bubble", {31'd0, bub_a}, 32'd1);
    chk("rst_cnt", cnt_a, 32'd0);

    // Back-to-back RAW on $3.
    drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd3, 0, 0, 6'd0, 0);
    drv(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 0, 6'd0, 0);
    at_neg();
    chk("raw_c1_sel", {30'd0, sel_a}, 32'd2);
    chk("raw_c1_bub", {31'd0, bub_a}, 32'd1);
    chk("raw_c1_sel_nobyp", {30'd0, sel_b}, 32'd2);
    step(); at_neg();
    chk("raw_c2_sel", {30'd0, sel_a}, 32'd2);
    step(); at_neg();
    chk("raw_c3_sel", {30'd0, sel_a}, 32'd0);
    chk("raw_c3_hold", {31'd0, hold_a}, 32'd0);
    chk("raw_cnt", cnt_a, 32'd2);
    chk("raw_c3_sel_nobyp", {30'd0, sel_b}, 32'd2);
    step(); at_neg();
    chk("raw_c4_sel_nobyp", {30'd0, sel_b}, 32'd0);
    chk("raw_cnt_nobyp", cnt_b, 32'd3);
    chk("raw_cnt_after", cnt_a, 32'd2);

    // $0 never tracked; unused rt ignored.
    do_reset();
    drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 0, 6'd0, 0);
    drv(1, 5'd0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 6'd0, 0);
    at_neg();
    chk("r0_sel", {30'd0, sel_a}, 32'd0);
    chk("r0_sel_nobyp", {30'd0, sel_b}, 32'd0);
    drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 0, 0, 6'd0, 0);
    drv(1, 5'd5, 0, 5'd5, 0, 0, 5'd0, 0, 0, 6'd0, 0);
    at_neg();
    chk("unused_sel", {30'd0, sel_a}, 32'd0);
    chk("unused_hold_nobyp", {31'd0, hold_b}, 32'd0);

    // Branch with operand still in MEM.
    do_reset();
    drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 0, 6'd0, 0);
    idle();
    drv(1, 5'd7, 1, 5'd0, 0, 0, 5'd0, 1, 0, 6'd0, 0);
    at_neg();
    chk("br_c1_sel", {30'd0, sel_a}, 32'd2);
    step(); at_neg();
    chk("br_c2_sel", {30'd0, sel_a}, 32'd1);
    chk("br_c2_hold", {31'd0, hold_a}, 32'd0);
    chk("br_c2_sel_nobyp", {30'd0, sel_b}, 32'd2);
    step(); at_neg();
    chk("br_c3_sel_nobyp", {30'd0, sel_b}, 32'd1);

    // Mult/div occupancy: div with 4 cycles, then mflo.
    do_reset();
    drv(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 6'd4, 1);
    drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd8, 0, 0, 6'd0, 1);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("md_stall_sel", {30'd0, sel_a}, 32'd2);
      chk("md_busy_hi", {31'd0, busy_a}, 32'd1);
      step();
    end
    at_neg();
    chk("md_done_sel", {30'd0, sel_a}, 32'd0);
    chk("md_done_busy", {31'd0, busy_a}, 32'd0);
    chk("md_cnt", cnt_a, 32'd4);
    drv(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 6'd0, 1);
    drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd8, 0, 0, 6'd0, 1);
    at_neg();
    chk("md_zero_busy", {31'd0, busy_a}, 32'd0);
    chk("md_zero_sel", {30'd0, sel_a}, 32'd0);

    // Async reset in the middle of an md stall with $9 in EX.
    idle();
    drv(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 6'd4, 1);
    drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 0, 6'd0, 0);
    drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd8, 0, 0, 6'd0, 1);
    at_neg();
    chk("ar_pre_busy", {31'd0, busy_a}, 32'd1);
    chk("ar_pre_sel", {30'd0, sel_a}, 32'd2);
    chk("ar_pre_cnt", cnt_a, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", {31'd0, busy_a}, 32'd0);
    chk("ar_hold", {31'd0, hold_a}, 32'd0);
    chk("ar_cnt", cnt_a, 32'd0);
    chk("ar_sel", {30'd0, sel_a}, 32'd0);
    chk("ar_bub", {31'd0, bub_a}, 32'd0);
    chk("ar_cnt_nobyp", cnt_b, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    drv(1, 5'd9, 1, 5'd0, 0, 0, 5'd0, 0, 0, 6'd0, 0);
    at_neg();
    chk("ar_after_sel", {30'd0, sel_a}, 32'd0);
    chk("ar_after_hold_nobyp", {31'd0, hold_b}, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ((n % 700) == 699) do_reset();
      begin
        bit md_r;
        md_r = ($urandom_range(0, 9) == 0);
        drv($urandom_range(0, 9) < 8,
            5'($urandom_range(0, 7)), $urandom_range(0, 9) < 6,
            5'($urandom_range(0, 7)), $urandom_range(0, 9) < 5,
            $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)),
            $urandom_range(0, 4) == 0, md_r, 6'($urandom_range(0, 7)),
            md_r || ($urandom_range(0, 6) == 0));
      end
    end
    idle();
    at_neg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
